// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/state types and decode helpers for the CPU controller
// Used by cpu_controller and cpu_ctrl_decode.
package cpu_pkg;

   localparam int OPCODE_W = 3;

   typedef enum logic [OPCODE_W-1:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } opcode_t;

   // Phases 0..7 map directly onto the low state bits; HALTED sits outside that range.
   typedef enum logic [3:0] {
      S_INST_ADDR  = 4'd0,
      S_INST_FETCH = 4'd1,
      S_INST_LOAD  = 4'd2,
      S_IDLE       = 4'd3,
      S_OP_ADDR    = 4'd4,
      S_OP_FETCH   = 4'd5,
      S_ALU_OP     = 4'd6,
      S_STORE      = 4'd7,
      S_HALTED     = 4'd8
   } state_t;

   localparam logic [2:0] PHASE_HALTED = 3'd7;

   // Bit n set means opcode n reads an operand into the accumulator (ADD, AND, XOR, LDA).
   localparam logic [7:0] ALU_OP_SET = 8'b0011_1100;

   function automatic logic [2:0] state_phase(input state_t s);
      return (s == S_HALTED) ? PHASE_HALTED : s[2:0];
   endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - combinational state/opcode to control-strobe decode
// Pure Moore decode: depends only on the state register and the held opcode.
module cpu_ctrl_decode
   import cpu_pkg::*;
#(
   parameter int OPCODE_WIDTH = 3
) (
   input  state_t                  state,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    zero,
   output logic                    sel,
   output logic                    rd,
   output logic                    ld_ir,
   output logic                    inc_pc,
   output logic                    ld_pc,
   output logic                    ld_ac,
   output logic                    wr,
   output logic                    data_e,
   output logic                    halt,
   output logic [2:0]              phase
);

   logic is_hlt;
   logic is_skz;
   logic is_sto;
   logic is_jmp;
   logic is_alu;

   assign is_hlt = (opcode == OPCODE_WIDTH'(OP_HLT));
   assign is_skz = (opcode == OPCODE_WIDTH'(OP_SKZ));
   assign is_sto = (opcode == OPCODE_WIDTH'(OP_STO));
   assign is_jmp = (opcode == OPCODE_WIDTH'(OP_JMP));
   assign is_alu = ((opcode >> 3) == '0) && ALU_OP_SET[opcode[2:0]];

   assign phase = state_phase(state);

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;
      case (state)
         S_INST_ADDR: begin
            sel = 1'b1;
         end
         S_INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         S_INST_LOAD, S_IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         S_OP_ADDR: begin
            inc_pc = 1'b1;
            halt   = is_hlt;
         end
         S_OP_FETCH: begin
            rd = is_alu;
         end
         // zero only matters here: SKZ skips by a second PC increment.
         S_ALU_OP: begin
            rd     = is_alu;
            inc_pc = is_skz & zero;
            ld_pc  = is_jmp;
            data_e = is_sto;
         end
         S_STORE: begin
            rd     = is_alu;
            ld_ac  = is_alu;
            ld_pc  = is_jmp;
            wr     = is_sto;
            data_e = is_sto;
         end
         S_HALTED: begin
            halt = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - eight-phase Moore instruction sequencer for the simple CPU
// Optional feature macro CTRL_RESUME_EN adds a resume input that leaves HALTED.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int OPCODE_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    zero,
`ifdef CTRL_RESUME_EN
   input  logic                    resume,
`endif
   output logic                    sel,
   output logic                    rd,
   output logic                    ld_ir,
   output logic                    inc_pc,
   output logic                    ld_pc,
   output logic                    ld_ac,
   output logic                    wr,
   output logic                    data_e,
   output logic                    halt,
   output logic [2:0]              phase
);

   state_t state;
   logic   is_hlt;

   assign is_hlt = (opcode == OPCODE_WIDTH'(OP_HLT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_INST_ADDR;
      end else begin
         case (state)
            S_INST_ADDR:  state <= S_INST_FETCH;
            S_INST_FETCH: state <= S_INST_LOAD;
            S_INST_LOAD:  state <= S_IDLE;
            S_IDLE:       state <= S_OP_ADDR;
            S_OP_ADDR:    state <= is_hlt ? S_HALTED : S_OP_FETCH;
            S_OP_FETCH:   state <= S_ALU_OP;
            S_ALU_OP:     state <= S_STORE;
            S_STORE:      state <= S_INST_ADDR;
`ifdef CTRL_RESUME_EN
            S_HALTED:     state <= resume ? S_INST_ADDR : S_HALTED;
`else
            S_HALTED:     state <= S_HALTED;
`endif
            default:      state <= S_INST_ADDR;
         endcase
      end
   end

   cpu_ctrl_decode #(
      .OPCODE_WIDTH (OPCODE_WIDTH)
   ) u_decode (
      .state  (state),
      .opcode (opcode),
      .zero   (zero),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .ld_ac  (ld_ac),
      .wr     (wr),
      .data_e (data_e),
      .halt   (halt),
      .phase  (phase)
   );

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed self-checking bench for cpu_controller
// Strobe vectors are packed {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}.
module tb_cpu_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] opcode = 3'd0;
   logic       zero = 1'b0;
`ifdef CTRL_RESUME_EN
   logic       resume = 1'b0;
`endif
   logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0] phase;
   logic [8:0] outs;

   int n_cmp = 0;
   int n_bad = 0;

   assign outs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

   always #5 clk = ~clk;

   cpu_controller #(.OPCODE_WIDTH(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .opcode (opcode),
      .zero   (zero),
`ifdef CTRL_RESUME_EN
      .resume (resume),
`endif
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .ld_ac  (ld_ac),
      .wr     (wr),
      .data_e (data_e),
      .halt   (halt),
      .phase  (phase)
   );

   localparam logic [35:0] FETCH_PART = {9'h1C0, 9'h1C0, 9'h180, 9'h100};
   localparam logic [71:0] EXP_ALU  = {9'h088, 9'h080, 9'h080, 9'h020, FETCH_PART};
   localparam logic [71:0] EXP_JMP  = {9'h010, 9'h010, 9'h000, 9'h020, FETCH_PART};
   localparam logic [71:0] EXP_SKZ1 = {9'h000, 9'h020, 9'h000, 9'h020, FETCH_PART};
   localparam logic [71:0] EXP_SKZ0 = {9'h000, 9'h000, 9'h000, 9'h020, FETCH_PART};
   localparam logic [71:0] EXP_STO  = {9'h006, 9'h002, 9'h000, 9'h020, FETCH_PART};
   localparam logic [71:0] EXP_HLT  = {9'h000, 9'h000, 9'h000, 9'h021, FETCH_PART};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks phases 0..nph-1, ticking between them; zmask drives zero per phase.
   task automatic run_phases(input string name, input logic [2:0] op, input logic [7:0] zmask,
                             input logic [71:0] exp, input int nph);
      opcode = op;
      for (int p = 0; p < nph; p++) begin
         zero = zmask[p];
         #1;
         check($sformatf("%s p%0d phase", name, p), {29'd0, phase}, p);
         check($sformatf("%s p%0d strobes", name, p), {23'd0, outs}, {23'd0, exp[p*9 +: 9]});
         check($sformatf("%s p%0d inc_pc&ld_pc", name, p), {31'd0, inc_pc & ld_pc}, 32'd0);
         check($sformatf("%s p%0d rd&wr", name, p), {31'd0, rd & wr}, 32'd0);
         if (p < nph - 1) tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset phase", {29'd0, phase}, 32'd0);
      check("reset strobes", {23'd0, outs}, 32'h100);

      run_phases("ADD", 3'd2, 8'hFF, EXP_ALU, 8);
      tick();
      run_phases("JMP", 3'd7, 8'h00, EXP_JMP, 8);
      tick();
      run_phases("SKZ z1", 3'd1, 8'h40, EXP_SKZ1, 8);
      tick();
      run_phases("SKZ z0", 3'd1, 8'hBF, EXP_SKZ0, 8);
      tick();
      run_phases("STO", 3'd6, 8'h00, EXP_STO, 8);
      tick();
`ifdef CTRL_RESUME_EN
      resume = 1'b1;
`endif
      run_phases("XOR", 3'd4, 8'h55, EXP_ALU, 8);
      tick();
`ifdef CTRL_RESUME_EN
      resume = 1'b0;
`endif

      run_phases("HLT", 3'd0, 8'h00, EXP_HLT, 5);
      tick();
      for (int i = 0; i < 20; i++) begin
         zero = 1'($urandom_range(0, 1));
         #1;
         check($sformatf("HALTED c%0d phase", i), {29'd0, phase}, 32'd7);
         check($sformatf("HALTED c%0d strobes", i), {23'd0, outs}, 32'h001);
         tick();
      end
`ifdef CTRL_RESUME_EN
      resume = 1'b1;
      tick();
      resume = 1'b0;
`else
      rst = 1'b1;
      tick();
      rst = 1'b0;
`endif
      check("exit HALTED phase", {29'd0, phase}, 32'd0);
      check("exit HALTED strobes", {23'd0, outs}, 32'h100);

      run_phases("LDA", 3'd5, 8'h00, EXP_ALU, 6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("LDA abort phase", {29'd0, phase}, 32'd0);
      check("LDA abort sel", {31'd0, sel}, 32'd1);
      check("LDA abort ld_ac", {31'd0, ld_ac}, 32'd0);
      check("LDA abort strobes", {23'd0, outs}, 32'h100);

      run_phases("AND", 3'd3, 8'h00, EXP_ALU, 8);
      tick();
      check("wrap phase", {29'd0, phase}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameter OPCODE_WIDTH, default 3: width of the opcode field.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 opcode  input  OPCODE_WIDTH  instruction opcode, held stable from the IR after INST_LOAD.
REQ-005 zero  input  1  accumulator-zero flag.
REQ-006 sel  output  1  address mux select: 1 = PC, 0 = IR operand.
REQ-007 rd  output  1  memory read strobe.
REQ-008 ld_ir  output  1  instruction-register load.
REQ-009 inc_pc  output  1  PC increment.
REQ-010 ld_pc  output  1  PC load from the operand address.
REQ-011 ld_ac  output  1  accumulator load.
REQ-012 wr  output  1  memory write strobe.
REQ-013 data_e  output  1  accumulator drives the data bus.
REQ-014 halt  output  1  CPU halted.
REQ-015 phase  output  3  current phase, encoded 0..7; 7 is also reported while HALTED.

Function
REQ-016 The controller SHALL be a Moore FSM.
- States: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), HALTED.
REQ-017 Transitions SHALL advance 0->1->...->7->0, one state per clock.
- Exception: in OP_ADDR with opcode==HLT, the next state SHALL be HALTED.
REQ-018 Opcodes SHALL be: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP is defined as ADD, AND, XOR or LDA.
REQ-019 Outputs SHALL be decoded from the state register and opcode only. All outputs are 0 unless listed below.
- INST_ADDR: sel.
- INST_FETCH: sel, rd.
- INST_LOAD and IDLE: sel, rd, ld_ir.
- OP_ADDR: inc_pc; halt=(opcode==HLT).
- OP_FETCH: rd=ALUOP.
- ALU_OP: rd=ALUOP; inc_pc=(SKZ && zero); ld_pc=JMP; data_e=STO.
- STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
- HALTED: halt only.
REQ-020 inc_pc and ld_pc SHALL never be asserted in the same cycle. The PC gives inc_pc priority, so overlap would corrupt jumps.
REQ-021 wr and rd SHALL never be asserted in the same cycle.
REQ-022 Every instruction SHALL take exactly 8 cycles, measured from INST_ADDR to the next INST_ADDR.
REQ-023 In HALTED, the FSM SHALL remain in HALTED until reset, or until resume when CTRL_RESUME_EN is defined.
REQ-024 The zero input SHALL be sampled only in ALU_OP. Its value in other states SHALL have no effect.

Reset
REQ-025 When rst=1 at a clock edge, state SHALL become INST_ADDR.
- The cycle after reset, outputs are: sel=1, phase=0, all other outputs 0.
REQ-026 Reset SHALL take priority over all transitions, including mid-instruction and HALTED.

Configuration
REQ-027 Macro CTRL_RESUME_EN defined:
- Adds input resume (1 bit).
- resume=1 in HALTED SHALL move the FSM to INST_ADDR on the next edge.
- resume SHALL be ignored in all other states.
REQ-028 Macro CTRL_RESUME_EN undefined:
- The resume port is absent.
- HALTED is exited only by rst.

Structure
REQ-029 Shared package cpu_pkg SHALL hold:
- the opcode enum (OPCODE_WIDTH bits);
- the state enum and its phase encodings;
- localparam ALU opcode set.
REQ-030 One sub-module, cpu_ctrl_decode, SHALL hold the combinational state/opcode-to-strobe decode. cpu_controller holds the state register and next-state logic.

Verification
REQ-031 Reset, then 8 cycles with opcode=ADD:
- phase sequence 0..7, then 0;
- rd=1 in phases 1,2,3,5,6,7;
- ld_ac=1 only in phase 7;
- inc_pc=1 only in phase 4.
REQ-032 opcode=JMP:
- ld_pc=1 in phases 6 and 7;
- inc_pc=1 only in phase 4;
- no cycle has ld_pc and inc_pc both high.
REQ-033 opcode=SKZ:
- with zero=1 in phase 6, inc_pc=1 in phases 4 and 6;
- with zero=0, inc_pc=1 only in phase 4.
REQ-034 opcode=STO:
- data_e=1 in phases 6 and 7;
- wr=1 only in phase 7;
- rd=0 in phases 5 to 7.
REQ-035 opcode=HLT:
- halt=1 in phase 4, then state HALTED with halt=1 held for 20 cycles.
- With CTRL_RESUME_EN defined, resume=1 gives phase=0 and halt=0 on the next cycle.
- Without CTRL_RESUME_EN, only rst exits HALTED.
REQ-036 rst=1 asserted during phase 5 of an LDA:
- next cycle phase=0 and sel=1;
- no ld_ac pulse is issued.
